// File: rtl/striping_sched.sv
`default_nettype none
// ============================================================================
//  Module   : striping_sched
//  Purpose  : Two-lane striping scheduler. Deals source words strictly
//             alternately to lane 0 and lane 1, tracks per-lane credits for
//             the downstream FIFOs and back-pressures the source when the
//             pending lane has no credit.
//  Ports    : clk_2f, reset        - clock, synchronous active-high reset
//             valid_in, data_in     - source word stream
//             ready_out             - word can be taken this cycle
//             lane_data, push_0/1   - registered word and lane write strobes
//             pop_0/1               - credit return from lane FIFOs
//             credit_0/1            - current credit counts
//             lane_ptr              - lane that receives the next word
//             state                 - 0 IDLE, 1 RUN, 2 STALL
//             cred_err              - sticky credit-overflow flag
//  Revision : 1.0 - initial release
// ============================================================================
module striping_sched #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int CRED_W = 3
) (
   input  logic              clk_2f,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              ready_out,
   output logic [DATA_W-1:0] lane_data,
   output logic              push_0,
   output logic              push_1,
   input  logic              pop_0,
   input  logic              pop_1,
   output logic [CRED_W-1:0] credit_0,
   output logic [CRED_W-1:0] credit_1,
   output logic              lane_ptr,
   output logic [1:0]        state,
   output logic              cred_err
);

   localparam logic [1:0]        c_st_idle   = 2'd0;
   localparam logic [1:0]        c_st_run    = 2'd1;
   localparam logic [1:0]        c_st_stall  = 2'd2;
   localparam logic [CRED_W-1:0] c_depth     = CRED_W'(DEPTH);
   localparam logic [CRED_W:0]   c_depth_ext = (CRED_W+1)'(DEPTH);

   logic              lane_ptr_q,  lane_ptr_d;
   logic [CRED_W-1:0] credit_0_q,  credit_0_d;
   logic [CRED_W-1:0] credit_1_q,  credit_1_d;
   logic [DATA_W-1:0] lane_data_q, lane_data_d;
   logic              push_0_q,    push_0_d;
   logic              push_1_q,    push_1_d;
   logic [1:0]        state_q,     state_d;
   logic              cred_err_q,  cred_err_d;

   logic              w_acc;
   logic              w_acc_0;
   logic              w_acc_1;
   logic [CRED_W:0]   w_sum_0;
   logic [CRED_W:0]   w_sum_1;

   // Only the pending lane's credit matters: strict ordering means the other
   // lane's credit can never let a word through.
   assign ready_out = !reset && (lane_ptr_q ? (credit_1_q != '0) : (credit_0_q != '0));
   assign w_acc     = valid_in && ready_out;
   assign w_acc_0   = w_acc && !lane_ptr_q;
   assign w_acc_1   = w_acc &&  lane_ptr_q;

   always_comb begin
      lane_ptr_d  = lane_ptr_q ^ w_acc;
      lane_data_d = w_acc ? data_in : lane_data_q;
      push_0_d    = w_acc_0;
      push_1_d    = w_acc_1;

      if (w_acc)
         state_d = c_st_run;
      else if (valid_in)
         state_d = c_st_stall;
      else
         state_d = c_st_idle;

      // One extra bit keeps the overflow visible; a decrement only happens
      // on a non-zero count, so the sum cannot wrap below zero.
      w_sum_0 = {1'b0, credit_0_q} + {{CRED_W{1'b0}}, pop_0} - {{CRED_W{1'b0}}, w_acc_0};
      w_sum_1 = {1'b0, credit_1_q} + {{CRED_W{1'b0}}, pop_1} - {{CRED_W{1'b0}}, w_acc_1};

      cred_err_d = cred_err_q;
      if (w_sum_0 > c_depth_ext) begin
         credit_0_d = c_depth;
         cred_err_d = 1'b1;
      end else begin
         credit_0_d = w_sum_0[CRED_W-1:0];
      end
      if (w_sum_1 > c_depth_ext) begin
         credit_1_d = c_depth;
         cred_err_d = 1'b1;
      end else begin
         credit_1_d = w_sum_1[CRED_W-1:0];
      end
   end

   // Reset overrides any accept or pop present in the same cycle, which also
   // cancels a push that would otherwise follow.
   always_ff @(posedge clk_2f) begin
      if (reset) begin
         lane_ptr_q  <= 1'b0;
         credit_0_q  <= c_depth;
         credit_1_q  <= c_depth;
         lane_data_q <= '0;
         push_0_q    <= 1'b0;
         push_1_q    <= 1'b0;
         state_q     <= c_st_idle;
         cred_err_q  <= 1'b0;
      end else begin
         lane_ptr_q  <= lane_ptr_d;
         credit_0_q  <= credit_0_d;
         credit_1_q  <= credit_1_d;
         lane_data_q <= lane_data_d;
         push_0_q    <= push_0_d;
         push_1_q    <= push_1_d;
         state_q     <= state_d;
         cred_err_q  <= cred_err_d;
      end
   end

   assign lane_data = lane_data_q;
   assign push_0    = push_0_q;
   assign push_1    = push_1_q;
   assign credit_0  = credit_0_q;
   assign credit_1  = credit_1_q;
   assign lane_ptr  = lane_ptr_q;
   assign state     = state_q;
   assign cred_err  = cred_err_q;

endmodule
`default_nettype wire

// File: tb/tb_striping_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_striping_sched
//  Purpose  : Self-checking bench for striping_sched. Expected lane writes
//             are queued when a word is driven that must be accepted, and
//             are consumed as push strobes appear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_striping_sched;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int CRED_W = 3;

   typedef struct {
      logic        lane;
      logic [31:0] data;
   } exp_t;

   logic              clk_2f = 1'b0;
   logic              reset = 1'b1;
   logic              valid_in = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic              pop_0 = 1'b0;
   logic              pop_1 = 1'b0;
   logic              ready_out;
   logic [DATA_W-1:0] lane_data;
   logic              push_0, push_1;
   logic [CRED_W-1:0] credit_0, credit_1;
   logic              lane_ptr;
   logic [1:0]        state;
   logic              cred_err;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   striping_sched #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CRED_W(CRED_W)) dut (
      .clk_2f   (clk_2f),
      .reset    (reset),
      .valid_in (valid_in),
      .data_in  (data_in),
      .ready_out(ready_out),
      .lane_data(lane_data),
      .push_0   (push_0),
      .push_1   (push_1),
      .pop_0    (pop_0),
      .pop_1    (pop_1),
      .credit_0 (credit_0),
      .credit_1 (credit_1),
      .lane_ptr (lane_ptr),
      .state    (state),
      .cred_err (cred_err)
   );

   always #5 clk_2f = ~clk_2f;

   // Scoreboard: every push strobe must match the oldest queued expectation.
   always @(negedge clk_2f) begin
      if (push_0 || push_1) begin
         checks++;
         if (push_0 && push_1) begin
            failures++;
            $display("FAIL sb_both_push got push_0=1 push_1=1 exp one strobe");
         end else if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected got push_%0d data=%h exp no push", push_1, lane_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (push_1 !== e.lane || lane_data !== e.data) begin
               failures++;
               $display("FAIL sb_word got lane=%0d data=%h exp lane=%0d data=%h",
                        push_1, lane_data, e.lane, e.data);
            end
         end
      end
   end

   // Apply inputs just after the rising edge, return at the falling edge
   // where outputs are sampled.
   task automatic step(input logic r, input logic v, input logic [31:0] d,
                       input logic p0, input logic p1);
      @(posedge clk_2f);
      #1;
      reset = r; valid_in = v; data_in = d; pop_0 = p0; pop_1 = p1;
      @(negedge clk_2f);
   endtask

   task automatic expect_word(input logic lane, input logic [31:0] d);
      exp_t e;
      e.lane = lane; e.data = d;
      sb.push_back(e);
   endtask

   task automatic apply_reset();
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0);
      checks++;
      if ({ready_out, lane_ptr, push_0, push_1, state, cred_err} !== 7'b0 ||
          lane_data !== 32'h0 || credit_0 !== 3'd4 || credit_1 !== 3'd4) begin
         failures++;
         $display("FAIL reset_state got rdy=%b ptr=%b p0=%b p1=%b st=%0d err=%b data=%h c0=%0d c1=%0d exp all 0, credits 4/4",
                  ready_out, lane_ptr, push_0, push_1, state, cred_err, lane_data, credit_0, credit_1);
      end
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_basic_order();
      logic [31:0] words [4];
      words[0] = 32'hFFFFFFFF; words[1] = 32'hEEEEEEEE;
      words[2] = 32'hDDDDDDDD; words[3] = 32'hCCCCCCCC;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, words[i], 1'b0, 1'b0);
         checks++;
         if (ready_out !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready[%0d] got=%b exp=1", i, ready_out);
         end
         expect_word(i[0], words[i]);
      end
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (credit_0 !== 3'd2 || credit_1 !== 3'd2 || lane_ptr !== 1'b0) begin
         failures++;
         $display("FAIL basic_credits got c0=%0d c1=%0d ptr=%0d exp 2 2 0", credit_0, credit_1, lane_ptr);
      end
   endtask

   task automatic test_stall();
      apply_reset();
      for (int i = 0; i < 2*DEPTH; i++) begin
         step(1'b0, 1'b1, 32'h100 + i, 1'b0, 1'b0);
         checks++;
         if (ready_out !== 1'b1) begin
            failures++;
            $display("FAIL stall_burst_ready[%0d] got=%b exp=1", i, ready_out);
         end
         expect_word(i[0], 32'h100 + i);
      end
      step(1'b0, 1'b1, 32'h109, 1'b0, 1'b0);
      checks++;
      if (ready_out !== 1'b0 || lane_ptr !== 1'b0 || credit_0 !== 3'd0 || credit_1 !== 3'd0) begin
         failures++;
         $display("FAIL stall_ninth got rdy=%b ptr=%b c0=%0d c1=%0d exp 0 0 0 0", ready_out, lane_ptr, credit_0, credit_1);
      end
      step(1'b0, 1'b1, 32'h109, 1'b0, 1'b1);
      checks++;
      if (state !== 2'd2 || ready_out !== 1'b0) begin
         failures++;
         $display("FAIL stall_state got st=%0d rdy=%b exp st=2 rdy=0", state, ready_out);
      end
      step(1'b0, 1'b1, 32'h109, 1'b0, 1'b0);
      checks++;
      if (credit_1 !== 3'd1 || ready_out !== 1'b0) begin
         failures++;
         $display("FAIL stall_pop1_held got c1=%0d rdy=%b exp c1=1 rdy=0", credit_1, ready_out);
      end
      step(1'b0, 1'b1, 32'h109, 1'b1, 1'b0);
      checks++;
      if (ready_out !== 1'b0) begin
         failures++;
         $display("FAIL stall_pop0_latency got rdy=%b exp=0", ready_out);
      end
      step(1'b0, 1'b1, 32'h109, 1'b0, 1'b0);
      checks++;
      if (ready_out !== 1'b1 || credit_0 !== 3'd1) begin
         failures++;
         $display("FAIL stall_release got rdy=%b c0=%0d exp rdy=1 c0=1", ready_out, credit_0);
      end
      expect_word(1'b0, 32'h109);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (state !== 2'd1 || lane_ptr !== 1'b1 || credit_0 !== 3'd0) begin
         failures++;
         $display("FAIL stall_after got st=%0d ptr=%b c0=%0d exp 1 1 0", state, lane_ptr, credit_0);
      end
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_gap();
      apply_reset();
      step(1'b0, 1'b1, 32'h00000003, 1'b0, 1'b0);
      expect_word(1'b0, 32'h00000003);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (state !== 2'd0 || lane_ptr !== 1'b1) begin
         failures++;
         $display("FAIL gap_idle got st=%0d ptr=%b exp st=0 ptr=1", state, lane_ptr);
      end
      step(1'b0, 1'b1, 32'h00000004, 1'b0, 1'b0);
      checks++;
      if (ready_out !== 1'b1) begin
         failures++;
         $display("FAIL gap_resume_ready got=%b exp=1", ready_out);
      end
      expect_word(1'b1, 32'h00000004);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_simultaneous();
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 32'h200 + i, 1'b0, 1'b0);
         expect_word(i[0], 32'h200 + i);
      end
      step(1'b0, 1'b1, 32'h77, 1'b1, 1'b0);
      checks++;
      if (credit_0 !== 3'd1 || lane_ptr !== 1'b0 || ready_out !== 1'b1) begin
         failures++;
         $display("FAIL simul_pre got c0=%0d ptr=%b rdy=%b exp 1 0 1", credit_0, lane_ptr, ready_out);
      end
      expect_word(1'b0, 32'h77);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (credit_0 !== 3'd1 || lane_ptr !== 1'b1) begin
         failures++;
         $display("FAIL simul_credit got c0=%0d ptr=%b exp c0=1 ptr=1", credit_0, lane_ptr);
      end
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_overflow();
      apply_reset();
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (credit_1 !== 3'd4 || cred_err !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set got c1=%0d err=%b exp c1=4 err=1", credit_1, cred_err);
      end
      step(1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
      expect_word(1'b0, 32'h300);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (cred_err !== 1'b1 || credit_0 !== 3'd3) begin
         failures++;
         $display("FAIL ovf_sticky got err=%b c0=%0d exp err=1 c0=3", cred_err, credit_0);
      end
      apply_reset();
      checks++;
      if (cred_err !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear got err=%b exp=0", cred_err);
      end
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      step(1'b0, 1'b1, 32'h401, 1'b0, 1'b0);
      expect_word(1'b0, 32'h401);
      step(1'b0, 1'b1, 32'h402, 1'b0, 1'b0);
      expect_word(1'b1, 32'h402);
      step(1'b1, 1'b1, 32'hAAAAAAAA, 1'b1, 1'b1);
      checks++;
      if (ready_out !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_ready got=%b exp=0", ready_out);
      end
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (push_0 !== 1'b0 || push_1 !== 1'b0 || credit_0 !== 3'd4 ||
          credit_1 !== 3'd4 || lane_ptr !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_state got p0=%b p1=%b c0=%0d c1=%0d ptr=%b exp 0 0 4 4 0",
                  push_0, push_1, credit_0, credit_1, lane_ptr);
      end
      step(1'b0, 1'b1, 32'h00000005, 1'b0, 1'b0);
      expect_word(1'b0, 32'h00000005);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic_order();
      test_stall();
      test_gap();
      test_simultaneous();
      test_overflow();
      test_reset_mid_burst();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain got pending=%0d exp 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/striping_sched.md
# striping_sched

Scheduler for the two-lane striping datapath. Accepts the 32-bit word stream on `valid_in`/`data_in` in the `clk_2f` domain and deals words strictly alternately to lane 0 and lane 1. Each lane's downstream buffer has a credit count; when the next lane in order has no credit, the scheduler back-pressures the source. It sits between the byte-unstriping/source side and the per-lane FIFOs that feed the `lane_0`/`lane_1` outputs.

## Interface
- `DATA_W`, default 32: word width.
- `DEPTH`, default 4: per-lane downstream buffer depth; this is the initial credit count.
- `CRED_W`, default 3: credit counter width; must hold the value `DEPTH`.

Ports (name, direction, width, meaning):
- `clk_2f`, in, 1: single clock; all logic runs on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `valid_in`, in, 1: a source word is present.
- `data_in`, in, DATA_W: source word.
- `ready_out`, out, 1: the scheduler can take a word this cycle.
- `lane_data`, out, DATA_W: registered word for the selected lane FIFO.
- `push_0`, `push_1`, out, 1 each: registered write strobes for the lane 0 and lane 1 FIFOs.
- `pop_0`, `pop_1`, in, 1 each: credit return; the lane FIFO freed one entry.
- `credit_0`, `credit_1`, out, CRED_W each: current credit counts.
- `lane_ptr`, out, 1: lane that receives the next accepted word.
- `state`, out, 2: status code, 0 = IDLE, 1 = RUN, 2 = STALL.
- `cred_err`, out, 1: sticky credit-overflow flag.

## Operation
- Accept rule: a word is accepted when `valid_in && ready_out`.
- `ready_out` = `!reset && (credit[lane_ptr] != 0)`.
- On accept:
  - `lane_data` <= `data_in`.
  - `push_<lane_ptr>` <= 1 and the other push <= 0.
  - `credit[lane_ptr]` is decremented.
  - `lane_ptr` toggles.
- No accept: both pushes <= 0; `lane_data` holds its last value.
- Ordering is strict:
  - If `credit[lane_ptr]` = 0, the scheduler stalls even when the other lane has credit.
  - `lane_ptr` never skips a lane.
- Gaps (`valid_in` = 0) do not move `lane_ptr`. A stream that resumes continues on the pending lane.
- Credit update per lane, every cycle: `cnt_next = cnt - acc_lane + pop_lane`.
  - Simultaneous accept and pop on the same lane leave the count unchanged.
  - A pop while the count is 0 is legal; the count becomes 1 if that lane is not also accepted.
- Overflow: a pop that would push a count above `DEPTH` saturates the count at `DEPTH` and sets `cred_err`. `cred_err` clears only on reset.
- `state` register, computed from this cycle's inputs and registered at the edge:
  - RUN if accept.
  - STALL if `valid_in && !ready_out`.
  - IDLE otherwise.
- Reset values (after a `reset`-high edge):
  - `lane_ptr`=0, `push_0`=`push_1`=0, `lane_data`=0.
  - `credit_0`=`credit_1`=`DEPTH`.
  - `state`=IDLE, `cred_err`=0.
  - `ready_out`=0 while `reset` is high.

## Timing
- `ready_out` is combinational from registered state (`lane_ptr`, credits) and `reset` only. It never depends on `valid_in`, so there is no combinational loop with the source.
- Latency: a word accepted at edge N appears on `lane_data` with its push strobe for the cycle after edge N (1 cycle).
- Throughput: 1 word/cycle while credits allow. With no pops, the sustained burst is `2*DEPTH` words.
- Credit counts and `lane_ptr` update at the accept edge. The next cycle's `ready_out` reflects them.
- A pop at edge N makes credit available for an accept in the cycle after N (1-cycle credit loop).
- Reset mid-operation:
  - Takes effect at the next edge and overrides accept and pop.
  - An in-flight push is cancelled: the strobe is 0 the cycle after reset.
  - Pops asserted during reset are ignored.

## Test plan
- Reset, then `valid_in`=1 with FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC and no pops:
  - `push_0` with FFFFFFFF, then `push_1` with EEEEEEEE, then `push_0` with DDDDDDDD, then `push_1` with CCCCCCCC, each 1 cycle after its accept.
  - Credits end at 2/2.
- Continuous valid with no pops:
  - 8 words are accepted.
  - On the 9th, `ready_out`=0, `state`=STALL, `lane_ptr`=0.
  - A single `pop_1` does not release the stall.
  - A `pop_0` releases it 1 cycle later.
- Gap test: accept 00000003, drop valid for 2 cycles, then send 00000004:
  - 00000003 goes to lane 0; 00000004 goes to lane 1.
  - `state` reads IDLE during the gap.
- Simultaneous event: `credit_0`=1, accept to lane 0 together with `pop_0` in the same cycle -> `credit_0` stays 1.
- Overflow: `pop_1` at `credit_1`=4 -> `credit_1` stays 4 and `cred_err`=1. `cred_err` stays 1 until reset.
- Reset mid-burst: assert `reset` while AAAAAAAA is accepted ->
  - no push the following cycle;
  - credits return to 4/4, `lane_ptr`=0;
  - the next word (00000005) goes to lane 0.
